regfile_wb: RTL and testbench
=============================

# regfile_wb

Register file with write-back pipeline register and operand bypass for the pipelined RISC CPU. It accepts results leaving the Execute stage and commits them to the register file one cycle later. It supplies the A and B register operands to Instruction Decode, including the B operand that the EX-stage operand select consumes. Reads are forwarded from in-flight results, so back-to-back dependent instructions see the newest value without software NOPs.

## Interface
Parameters:
- DATA_WIDTH, 16, register and result width
- ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- ex_rw  input  1  EX instruction writes a register
- ex_dest  input  ADDR_WIDTH  EX destination register
- ex_result  input  DATA_WIDTH  EX result value
- ex_is_load  input  1  EX result not yet valid (memory load)
- stall  input  1  pipeline stall; EX is held upstream
- flush  input  1  squash the EX instruction (branch taken)
- id_sa  input  ADDR_WIDTH  ID read address A
- id_sb  input  ADDR_WIDTH  ID read address B
- a_data  output  DATA_WIDTH  operand A to ID/EX
- b_data  output  DATA_WIDTH  operand B to ID/EX (feeds B operand select)
- stall_req  output  1  load-use hazard; request one-cycle stall
- wb_we, wb_dest, wb_data  output  1/ADDR_WIDTH/DATA_WIDTH  W stage contents, for debug and bench observation

## Operation
- W stage register holds {we, dest, data}. On each edge:
  - rst: we=0, dest=0, data=0; all registers cleared to 0.
  - else if flush or stall: W loads a bubble (we=0; dest and data don't-care, held).
  - else: W loads {ex_rw && ex_dest!=0, ex_dest, ex_result}.
- Commit: on each non-reset edge where W.we=1, regs[W.dest] <= W.data. The commit uses W's value from before that edge, so the commit and the next W capture occur on the same edge.
- R0 is hardwired to 0. Writes to R0 are dropped at W capture. Reads of address 0 return 0 and are never forwarded.
- Read path is combinational and applies per port (A and B independently), first match wins:
  - address==0 -> 0.
  - ex_rw && !flush && ex_dest==addr && !ex_is_load -> ex_result.
  - W.we && W.dest==addr -> W.data.
  - otherwise regs[addr].
- stall_req = ex_is_load && ex_rw && !flush && ex_dest!=0 && (ex_dest==id_sa || ex_dest==id_sb). The block does not stall itself. It acts only on the stall input.
- Widths are fixed. There is no arithmetic and no truncation.

## Timing
- Write latency: a result presented at EX in cycle N is captured in W at edge N+1 and committed to regs at edge N+2.
- Readable via EX bypass in cycle N, via W bypass in cycle N+1, and via regs from cycle N+2 onward.
- Reset: a_data and b_data read 0 for all addresses in the cycle after the reset edge. stall_req depends only on inputs.
- Stall: a stalled EX instruction re-presents its result each cycle and is captured on the first non-stall, non-flush edge. W still commits its pending value on the stall edge.
- Flush and stall together: treated as flush; W loads a bubble.
- Reset asserted mid-write: reset wins; no commit occurs on that edge.
- Same address from EX and W: the EX value wins (it is newer).

## Test plan
- Reset: write 0x1234 to R3, then assert rst for 1 cycle -> regs, W and a_data(R3) all 0 afterward.
- Write latency: EX writes R5=0xBEEF in cycle 0, id_sb=5 -> b_data=0xBEEF in cycles 0 (EX bypass), 1 (W bypass) and 2+ (regs). wb_we=1 only in cycle 1.
- Priority: R7=0x0001 in W while EX writes R7=0x0002, id_sa=id_sb=7 -> a_data=b_data=0x0002. After two edges regs[7]=0x0002.
- R0 guard: EX writes R0=0xFFFF -> wb_we=0 next cycle and a_data(0)=0 at all times.
- Stall and flush: EX writes R2=0x00AA with stall=1 for 2 cycles -> wb_we=0 during the stall, captured after release. The same instruction with flush=1 -> R2 unchanged and no bypass.
- Load-use: ex_is_load=1, ex_dest=4, id_sb=4 -> stall_req=1 and b_data not taken from ex_result. With id_sa=id_sb=6 -> stall_req=0.

Source files
------------

// File: rtl/regfile_wb_if.sv
// Bundle of EX-side write, ID-side read and W-stage debug signals for regfile_wb.
interface regfile_wb_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 5
);
   logic                  ex_rw;
   logic [ADDR_WIDTH-1:0] ex_dest;
   logic [DATA_WIDTH-1:0] ex_result;
   logic                  ex_is_load;
   logic                  stall;
   logic                  flush;
   logic [ADDR_WIDTH-1:0] id_sa;
   logic [ADDR_WIDTH-1:0] id_sb;
   logic [DATA_WIDTH-1:0] a_data;
   logic [DATA_WIDTH-1:0] b_data;
   logic                  stall_req;
   logic                  wb_we;
   logic [ADDR_WIDTH-1:0] wb_dest;
   logic [DATA_WIDTH-1:0] wb_data;

   modport master (
      output ex_rw, ex_dest, ex_result, ex_is_load, stall, flush, id_sa, id_sb,
      input  a_data, b_data, stall_req, wb_we, wb_dest, wb_data
   );

   modport slave (
      input  ex_rw, ex_dest, ex_result, ex_is_load, stall, flush, id_sa, id_sb,
      output a_data, b_data, stall_req, wb_we, wb_dest, wb_data
   );
endinterface

// File: rtl/regfile_wb.sv
// Register file with a write-back pipeline register and EX/W operand bypass.
// R0 reads as zero; loads in EX are not forwarded and raise a load-use stall request.
module regfile_wb #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input logic         clk,
   input logic         rst,
   regfile_wb_if.slave bus
);
   localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] dest_q, dest_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  ex_live;
   logic                  ex_fwd;

   assign ex_live = bus.ex_rw && !bus.flush && (bus.ex_dest != '0);
   assign ex_fwd  = ex_live && !bus.ex_is_load;

   function automatic logic [DATA_WIDTH-1:0] read_port(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic                  ex_ok,
      input logic [ADDR_WIDTH-1:0] ex_dest,
      input logic [DATA_WIDTH-1:0] ex_result,
      input logic                  w_we,
      input logic [ADDR_WIDTH-1:0] w_dest,
      input logic [DATA_WIDTH-1:0] w_data,
      input logic [DATA_WIDTH-1:0] reg_val
   );
      logic [DATA_WIDTH-1:0] val;
      if (addr == '0) begin
         val = '0;
      end else if (ex_ok && (ex_dest == addr)) begin
         val = ex_result;
      end else if (w_we && (w_dest == addr)) begin
         val = w_data;
      end else begin
         val = reg_val;
      end
      return val;
   endfunction

   always_comb begin
      we_d   = we_q;
      dest_d = dest_q;
      data_d = data_q;
      if (bus.flush || bus.stall) begin
         we_d = 1'b0;
      end else begin
         we_d   = bus.ex_rw && (bus.ex_dest != '0);
         dest_d = bus.ex_dest;
         data_d = bus.ex_result;
      end
   end

   // Commit uses the W contents from before the edge, alongside the next W capture.
   always_comb begin
      regs_d = regs_q;
      if (we_q) begin
         regs_d[dest_q] = data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q   <= 1'b0;
         dest_q <= '0;
         data_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         we_q   <= we_d;
         dest_q <= dest_d;
         data_q <= data_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign bus.a_data = read_port(bus.id_sa, ex_fwd, bus.ex_dest, bus.ex_result,
                                 we_q, dest_q, data_q, regs_q[bus.id_sa]);
   assign bus.b_data = read_port(bus.id_sb, ex_fwd, bus.ex_dest, bus.ex_result,
                                 we_q, dest_q, data_q, regs_q[bus.id_sb]);

   assign bus.stall_req = bus.ex_is_load && ex_live &&
                          ((bus.ex_dest == bus.id_sa) || (bus.ex_dest == bus.id_sb));

   assign bus.wb_we   = we_q;
   assign bus.wb_dest = dest_q;
   assign bus.wb_data = data_q;
endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb: latency, bypass priority, R0, stall/flush, load-use.
module tb_regfile_wb;
   localparam int unsigned DW = 16;
   localparam int unsigned AW = 5;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   regfile_wb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   regfile_wb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.ex_rw      = 1'b0;
      bus.ex_dest    = '0;
      bus.ex_result  = '0;
      bus.ex_is_load = 1'b0;
      bus.stall      = 1'b0;
      bus.flush      = 1'b0;
   endtask

   task automatic ex_write(input logic [AW-1:0] d, input logic [DW-1:0] v);
      bus.ex_rw     = 1'b1;
      bus.ex_dest   = d;
      bus.ex_result = v;
   endtask

   // Advance one edge and settle; inputs change and checks happen away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      idle();
      bus.id_sa = '0;
      bus.id_sb = '0;
      step();
      rst = 1'b0;
      #1;
      check_eq("reset_wb_we", {31'd0, bus.wb_we}, 32'd0);
      check_eq("reset_wb_data", {16'd0, bus.wb_data}, 32'd0);

      // Reset clears a committed register.
      ex_write(5'd3, 16'h1234);
      step();
      idle();
      step();
      bus.id_sa = 5'd3;
      #1;
      check_eq("pre_reset_r3", {16'd0, bus.a_data}, 32'h1234);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check_eq("post_reset_r3", {16'd0, bus.a_data}, 32'h0);
      check_eq("post_reset_wb_we", {31'd0, bus.wb_we}, 32'd0);
      check_eq("post_reset_wb_dest", {27'd0, bus.wb_dest}, 32'd0);

      // Reset while W holds a pending write: no commit.
      ex_write(5'd3, 16'h5555);
      step();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check_eq("reset_midwrite_r3", {16'd0, bus.a_data}, 32'h0);

      // Write latency R5 = 0xBEEF.
      bus.id_sb = 5'd5;
      ex_write(5'd5, 16'hBEEF);
      #1;
      check_eq("lat_c0_b", {16'd0, bus.b_data}, 32'hBEEF);
      check_eq("lat_c0_we", {31'd0, bus.wb_we}, 32'd0);
      step();
      idle();
      #1;
      check_eq("lat_c1_b", {16'd0, bus.b_data}, 32'hBEEF);
      check_eq("lat_c1_we", {31'd0, bus.wb_we}, 32'd1);
      check_eq("lat_c1_dest", {27'd0, bus.wb_dest}, 32'd5);
      step();
      check_eq("lat_c2_b", {16'd0, bus.b_data}, 32'hBEEF);
      check_eq("lat_c2_we", {31'd0, bus.wb_we}, 32'd0);
      step();
      check_eq("lat_c3_b", {16'd0, bus.b_data}, 32'hBEEF);

      // EX beats W on the same address.
      ex_write(5'd7, 16'h0001);
      step();
      ex_write(5'd7, 16'h0002);
      bus.id_sa = 5'd7;
      bus.id_sb = 5'd7;
      #1;
      check_eq("prio_a", {16'd0, bus.a_data}, 32'h0002);
      check_eq("prio_b", {16'd0, bus.b_data}, 32'h0002);
      step();
      idle();
      #1;
      check_eq("prio_w_a", {16'd0, bus.a_data}, 32'h0002);
      step();
      step();
      check_eq("prio_regs_a", {16'd0, bus.a_data}, 32'h0002);

      // R0 guard.
      bus.id_sa = 5'd0;
      ex_write(5'd0, 16'hFFFF);
      #1;
      check_eq("r0_ex_a", {16'd0, bus.a_data}, 32'h0);
      step();
      idle();
      #1;
      check_eq("r0_wb_we", {31'd0, bus.wb_we}, 32'd0);
      check_eq("r0_w_a", {16'd0, bus.a_data}, 32'h0);
      step();
      check_eq("r0_regs_a", {16'd0, bus.a_data}, 32'h0);

      // Stall holds EX out of W; the pending W commit still happens on the stall edge.
      ex_write(5'd9, 16'h0909);
      step();
      ex_write(5'd2, 16'h00AA);
      bus.stall = 1'b1;
      step();
      bus.id_sb = 5'd9;
      #1;
      check_eq("stall1_we", {31'd0, bus.wb_we}, 32'd0);
      check_eq("stall_commit_r9", {16'd0, bus.b_data}, 32'h0909);
      step();
      bus.stall = 1'b0;
      #1;
      check_eq("stall2_we", {31'd0, bus.wb_we}, 32'd0);
      step();
      idle();
      #1;
      check_eq("release_we", {31'd0, bus.wb_we}, 32'd1);
      check_eq("release_dest", {27'd0, bus.wb_dest}, 32'd2);
      check_eq("release_data", {16'd0, bus.wb_data}, 32'h00AA);
      step();
      step();

      // Flush: no capture, no bypass.
      bus.id_sa = 5'd2;
      ex_write(5'd2, 16'h0055);
      bus.flush = 1'b1;
      #1;
      check_eq("flush_no_bypass", {16'd0, bus.a_data}, 32'h00AA);
      step();
      idle();
      #1;
      check_eq("flush_we", {31'd0, bus.wb_we}, 32'd0);
      step();
      check_eq("flush_r2_kept", {16'd0, bus.a_data}, 32'h00AA);

      // Flush together with stall acts as flush.
      ex_write(5'd2, 16'h0066);
      bus.flush = 1'b1;
      bus.stall = 1'b1;
      step();
      idle();
      #1;
      check_eq("flush_stall_we", {31'd0, bus.wb_we}, 32'd0);
      step();
      check_eq("flush_stall_r2", {16'd0, bus.a_data}, 32'h00AA);

      // Load-use hazard.
      ex_write(5'd4, 16'h4444);
      bus.ex_is_load = 1'b1;
      bus.id_sa = 5'd1;
      bus.id_sb = 5'd4;
      #1;
      check_eq("load_stall_req", {31'd0, bus.stall_req}, 32'd1);
      check_eq("load_no_fwd_b", {16'd0, bus.b_data}, 32'h0);
      bus.id_sa = 5'd6;
      bus.id_sb = 5'd6;
      #1;
      check_eq("load_other_req", {31'd0, bus.stall_req}, 32'd0);
      bus.id_sa = 5'd4;
      bus.flush = 1'b1;
      #1;
      check_eq("load_flush_req", {31'd0, bus.stall_req}, 32'd0);
      bus.flush = 1'b0;
      bus.ex_dest = 5'd0;
      bus.id_sa = 5'd0;
      #1;
      check_eq("load_r0_req", {31'd0, bus.stall_req}, 32'd0);
      idle();
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule
